// File: rtl/l2_arbiter.sv
// Four-client arbiter for the single L2 port: round-robin among ICache, DCache and IOMMU,
// with a starvation-promoted prefetcher, one outstanding L2 access and a BUSY-state watchdog.
module l2_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int PF_MAX_WAIT = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [3:0]            req_we,
    input  logic [4*LINE_W-1:0]   req_wdata,
    output logic [3:0]            done,
    output logic [3:0]            err,
    output logic [LINE_W-1:0]     rdata,
    output logic                  busy,
    output logic [1:0]            grant_id,
    output logic [ADDR_W-1:0]     l2_paddr,
    output logic                  l2_request,
    output logic                  l2_write_en,
    output logic [LINE_W-1:0]     l2_write_data,
    input  logic [LINE_W-1:0]     l2_data,
    input  logic                  l2_done,
    output logic [1:0]            dbg_state
);

    // Handshake: a client holds req (and its addr/we/wdata) until it sees its done or err bit;
    // l2_request stays high from grant until l2_done is sampled or the watchdog expires, and
    // l2_data is taken only on a cycle where l2_done is high while an access is outstanding.

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int PF_W = $clog2(PF_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      rr_last;
    logic [PF_W-1:0] pf_wait;
    logic [WD_W-1:0] wd_cnt;
    logic [1:0]      winner;
    logic            pf_promote;
    logic            grant_pf;
    logic            winner_writes;

    assign dbg_state = state;

    // Prefetcher wins when it is alone or has waited long enough; otherwise rotate over 0..2.
    always_comb begin
        pf_promote = req[3] && ((req[2:0] == 3'b000) || (pf_wait >= PF_W'(PF_MAX_WAIT)));
        winner     = 2'd3;
        if (!pf_promote) begin
            case (rr_last)
                2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
                2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
                default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
            endcase
        end
    end

    assign grant_pf      = (state == IDLE) && (req != 4'b0000) && (winner == 2'd3);
    assign winner_writes = (winner == 2'd1) || (winner == 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pf_wait <= '0;
        end else if (!req[3] || grant_pf) begin
            pf_wait <= '0;
        end else if (pf_wait != PF_W'(PF_MAX_WAIT)) begin
            pf_wait <= pf_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_last       <= 2'd2;
            wd_cnt        <= '0;
            done          <= '0;
            err           <= '0;
            rdata         <= '0;
            busy          <= 1'b0;
            grant_id      <= 2'd0;
            l2_paddr      <= '0;
            l2_request    <= 1'b0;
            l2_write_en   <= 1'b0;
            l2_write_data <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (req != 4'b0000) begin
                        grant_id      <= winner;
                        l2_paddr      <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                        l2_write_en   <= req_we[winner] && winner_writes;
                        l2_write_data <= winner_writes ? req_wdata[int'(winner)*LINE_W +: LINE_W] : '0;
                        l2_request    <= 1'b1;
                        busy          <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= BUSY;
                        if (winner != 2'd3) begin
                            rr_last <= winner;
                        end
                    end
                end
                BUSY: begin
                    // A completion on the watchdog's last cycle still counts as success.
                    if (l2_done) begin
                        rdata            <= l2_data;
                        done[grant_id]   <= 1'b1;
                        l2_request       <= 1'b0;
                        state            <= RESP;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        err[grant_id]    <= 1'b1;
                        l2_request       <= 1'b0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios with literal expectations, then randomized clients
// and L2 latencies checked every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_l2_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int PF_MAX = 16;
    localparam int TMO    = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [3:0]          req = '0;
    logic [4*ADDR_W-1:0] req_addr = '0;
    logic [3:0]          req_we = '0;
    logic [4*LINE_W-1:0] req_wdata = '0;
    logic [LINE_W-1:0]   l2_data = '0;
    logic                l2_done = 1'b0;

    logic [3:0]          done, err;
    logic [LINE_W-1:0]   rdata, l2_write_data;
    logic                busy, l2_request, l2_write_en;
    logic [1:0]          grant_id, dbg_state;
    logic [ADDR_W-1:0]   l2_paddr;

    int n_vec = 0;
    int n_err = 0;

    l2_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .PF_MAX_WAIT(PF_MAX), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .grant_id(grant_id), .l2_paddr(l2_paddr), .l2_request(l2_request),
        .l2_write_en(l2_write_en), .l2_write_data(l2_write_data), .l2_data(l2_data),
        .l2_done(l2_done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_W/32; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    // ---------------- reference model ----------------
    // Transactions are tracked by the edge they were granted on; elapsed BUSY cycles are
    // the difference between the current edge number and the grant edge.
    int                m_t = 0;
    bit                m_open;
    int                m_grant_t;
    int                m_g;
    int                m_rr_last;
    int                m_pf_run;
    logic [3:0]        e_done, e_err;
    logic              e_busy, e_req, e_we;
    logic [1:0]        e_gid;
    logic [ADDR_W-1:0] e_paddr;
    logic [LINE_W-1:0] e_wdata, e_rdata;

    task automatic model_reset();
        m_open = 1'b0; m_grant_t = 0; m_g = 0; m_rr_last = 2; m_pf_run = 0;
        e_done = '0; e_err = '0; e_busy = 1'b0; e_req = 1'b0; e_we = 1'b0;
        e_gid = '0; e_paddr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    task automatic model_step();
        int w;
        int c;
        w = -1;
        m_t++;
        e_done = '0;
        e_err  = '0;
        if (m_open) begin
            if (l2_done) begin
                e_rdata = l2_data; e_done[m_g] = 1'b1; e_req = 1'b0; m_open = 1'b0;
            end else if (m_t - m_grant_t == TMO) begin
                e_err[m_g] = 1'b1; e_req = 1'b0; e_busy = 1'b0; m_open = 1'b0;
            end
        end else if (e_busy) begin
            e_busy = 1'b0;
        end else if (req != 4'b0000) begin
            if (req[3] && (req[2:0] == 3'b000 || m_pf_run >= PF_MAX)) begin
                w = 3;
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    c = (m_rr_last + k) % 3;
                    if (w < 0 && req[c]) w = c;
                end
                m_rr_last = w;
            end
            m_g = w; m_grant_t = m_t; m_open = 1'b1;
            e_gid = 2'(w); e_req = 1'b1; e_busy = 1'b1;
            e_paddr = req_addr[w*ADDR_W +: ADDR_W];
            e_we    = req_we[w] && (w == 1 || w == 2);
            e_wdata = req_wdata[w*LINE_W +: LINE_W];
        end
        if (!req[3] || w == 3) m_pf_run = 0;
        else m_pf_run++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("done", done, e_done);
            check("err", err, e_err);
            check("busy", busy, e_busy);
            check("grant_id", grant_id, e_gid);
            check("l2_request", l2_request, e_req);
            if (e_req || !reset) begin
                check("l2_paddr", l2_paddr, e_paddr);
                check("l2_write_en", l2_write_en, e_we);
            end
            if ((e_req && e_we) || !reset) check("l2_write_data", l2_write_data, e_wdata);
            if (e_done != 4'b0000 || !reset) check("rdata", rdata, e_rdata);
            if (!reset) check("reset_state", dbg_state, 2'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        req = '0; l2_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic record_grants(input int cycles, output int ids[$], output int cyc[$]);
        logic prev;
        prev = 1'b0;
        ids.delete();
        cyc.delete();
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (l2_request && !prev) begin
                ids.push_back(int'(grant_id));
                cyc.push_back(c);
            end
            prev = l2_request;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ids[$];
        int cyc[$];
        int exp_rr[6] = '{0, 1, 2, 0, 1, 2};
        int exp_pf[8] = '{0, 1, 0, 1, 0, 1, 3, 0};
        int resp_delay;
        int seen_grant_t;
        int r;

        repeat (2) @(negedge clk);
        check("rst_done", done, 4'b0000);
        check("rst_l2_request", l2_request, 1'b0);

        // ICache read; we bit of client 0 must be ignored
        reset = 1'b1;
        req = 4'b0001; req_we = 4'b1001;
        req_addr[0 +: ADDR_W] = 32'h0000_1040;
        @(negedge clk);
        check("ic_paddr", l2_paddr, 32'h0000_1040);
        check("ic_write_en", l2_write_en, 1'b0);
        check("ic_request", l2_request, 1'b1);
        @(negedge clk);
        l2_done = 1'b1; l2_data = {32{8'hA5}};
        @(negedge clk);
        check("ic_done", done, 4'b0001);
        check("ic_rdata", rdata, {32{8'hA5}});
        l2_done = 1'b0; req = '0; req_we = '0;
        @(negedge clk);
        check("ic_busy_fall", busy, 1'b0);

        // DCache write
        req = 4'b0010; req_we = 4'b0010;
        req_addr[ADDR_W +: ADDR_W] = 32'h0000_2000;
        req_wdata[LINE_W +: LINE_W] = {16{16'h1234}};
        @(negedge clk);
        check("dc_write_en", l2_write_en, 1'b1);
        check("dc_write_data", l2_write_data, {16{16'h1234}});
        check("dc_paddr", l2_paddr, 32'h0000_2000);
        l2_done = 1'b1; l2_data = rand_line();
        @(negedge clk);
        check("dc_done", done, 4'b0010);
        l2_done = 1'b0; req = '0; req_we = '0;
        @(negedge clk);

        // Round-robin with single-cycle L2
        do_reset();
        req = 4'b0111; l2_done = 1'b1;
        record_grants(18, ids, cyc);
        check("rr_count", ids.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ids.size()) begin
                check("rr_order", ids[i], exp_rr[i]);
                if (i > 0) check("rr_spacing", cyc[i] - cyc[i-1], 3);
            end
        end

        // Prefetch starvation promotion
        do_reset();
        req = 4'b1011; l2_done = 1'b1;
        record_grants(24, ids, cyc);
        check("pf_count", ids.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < ids.size()) check("pf_order", ids[i], exp_pf[i]);
        end

        // Watchdog timeout on client 2
        do_reset();
        req = 4'b0100; l2_done = 1'b0;
        repeat (8) @(negedge clk);
        check("to_err_early", err, 4'b0000);
        check("to_request_held", l2_request, 1'b1);
        @(negedge clk);
        check("to_err", err, 4'b0100);
        check("to_no_done", done, 4'b0000);
        check("to_request_drop", l2_request, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        check("to_next_grant", grant_id, 2'd0);
        check("to_next_request", l2_request, 1'b1);
        l2_done = 1'b1;
        @(negedge clk);
        req = '0; l2_done = 1'b0;
        @(negedge clk);

        // Reset while waiting on L2, after a grant to client 1
        req = 4'b0010;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mr_request", l2_request, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_paddr", l2_paddr, 32'h0);
        check("mr_grant", grant_id, 2'd0);
        @(negedge clk);
        req = 4'b0111; reset = 1'b1;
        @(negedge clk);
        check("mr_first_grant", grant_id, 2'd0);
        check("mr_first_request", l2_request, 1'b1);
        l2_done = 1'b1;
        @(negedge clk);
        req = '0; l2_done = 1'b0;
        @(negedge clk);

        // Randomized clients and L2 latency
        seen_grant_t = -1;
        resp_delay = 0;
        for (int cycle = 0; cycle < 3000; cycle++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && (e_done[i] || e_err[i])) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    req_addr[i*ADDR_W +: ADDR_W] = $urandom();
                    req_we[i] = 1'($urandom_range(0, 1));
                    req_wdata[i*LINE_W +: LINE_W] = rand_line();
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
            end
            l2_data = rand_line();
            if (m_open) begin
                if (m_grant_t != seen_grant_t) begin
                    seen_grant_t = m_grant_t;
                    r = $urandom_range(0, 15);
                    if (r < 10) resp_delay = r % 5;
                    else if (r < 12) resp_delay = TMO - 1;
                    else if (r == 12) resp_delay = TMO - 2;
                    else resp_delay = 100;
                end
                l2_done = ((m_t - m_grant_t) == resp_delay);
            end else begin
                l2_done = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Shares the single L2 cache port among the four L2 clients: L1 ICache (0), L1 DCache (1), IOMMU (2) and prefetcher (3). It replaces the OR-combined request, address and write-data buses with one granted transaction at a time. It registers the winning client's request, drives the L2 port until `l2_done` arrives, then returns the line and a one-cycle done pulse to that client only. A watchdog aborts a hung L2 access and reports it to the client.

## Interface
- `ADDR_W`, 32, physical address width per client
- `LINE_W`, 256, L2 line width for read data and write data
- `PF_MAX_WAIT`, 16, cycles a pending prefetch may be starved before it is promoted
- `TIMEOUT`, 1024, maximum cycles in BUSY before abort
- `clk`  in  1  clock, all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  4  per-client request level; bit i is client i
- `req_addr`  in  4*ADDR_W  client i address at `[i*ADDR_W +: ADDR_W]`
- `req_we`  in  4  write enable; bits 0 and 3 are ignored and treated as 0
- `req_wdata`  in  4*LINE_W  client i write line at `[i*LINE_W +: LINE_W]`; only clients 1 and 2 are used
- `done`  out  4  one-cycle completion pulse to the granted client
- `err`  out  4  one-cycle timeout pulse to the granted client
- `rdata`  out  LINE_W  returned line; valid while any `done` bit is high
- `busy`  out  1  high in BUSY and RESP
- `grant_id`  out  2  current or last granted client
- `l2_paddr`  out  ADDR_W  registered address to L2
- `l2_request`  out  1  L2 request level
- `l2_write_en`  out  1  L2 write enable
- `l2_write_data`  out  LINE_W  L2 write line
- `l2_data`  in  LINE_W  L2 read line, sampled when `l2_done` is high
- `l2_done`  in  1  L2 completion

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If `req` is nonzero, select a winner.
  - Latch that client's addr, we and wdata into the `l2_*` registers and set `grant_id`.
  - Go to BUSY.
- BUSY:
  - `l2_request` is held at 1.
  - On `l2_done`, capture `l2_data` into `rdata` and go to RESP.
  - If the watchdog count reaches `TIMEOUT-1` without `l2_done`, pulse `err[grant_id]`, drop `l2_request` and go to IDLE.
- RESP:
  - `done[grant_id]` is 1 for exactly this cycle.
  - `l2_request` is 0.
  - Next state is IDLE.
- Winner selection:
  - Clients 0–2 are round-robin. The search starts at `rr_last+1` (mod 3), and `rr_last` updates on each grant to a client in 0–2.
  - Client 3 wins only if `req[2:0]==0`, or if `pf_wait >= PF_MAX_WAIT`. In the second case it beats clients 0–2.
- `pf_wait` counter:
  - Increments each cycle that `req[3]` is high and client 3 is not being granted.
  - Saturates at `PF_MAX_WAIT`.
  - Clears on a grant to client 3 and whenever `req[3]` is 0.
- A client drops `req` in the cycle it sees `done` or `err`.
- A `req` drop while that client is granted is ignored; the transaction completes and `done` is still pulsed.
- Inputs from non-granted clients are never forwarded to L2.
- `l2_write_en` is 1 only for clients 1 and 2 when `req_we` is set for them.
- Reset:
  - Values after reset: all outputs 0, state IDLE, `rr_last=2` (so client 0 is searched first), `pf_wait=0`, watchdog 0.
  - Reset asserted mid-transaction abandons it with no `done` or `err`.

## Timing
- `req` high at edge N, in IDLE → `l2_request`, `l2_paddr` and `grant_id` are valid after edge N.
- `l2_done` sampled at edge M → `done` and `rdata` are valid in cycle M+1, RESP.
- IDLE at M+2; the next grant drives `l2_request` after edge M+2.
- Minimum occupancy is 3 cycles per transaction when `l2_done` arrives in the first BUSY cycle.
- `l2_request` falls for at least one cycle (the RESP cycle) between transactions.
- The watchdog counts from 0 at BUSY entry. The abort edge is the `TIMEOUT`-th BUSY cycle, and `err` is high in the following cycle while the state is IDLE.
- `l2_done` arriving in the same cycle as the watchdog limit: done wins, no `err`.
- `l2_done` in IDLE or RESP is ignored.

## Test plan
- ICache-only read: `req=4'b0001`, addr `0x0000_1040`, L2 returns line `0xA5…A5` two cycles after request → `l2_paddr=0x0000_1040`, `l2_write_en=0`, `done=4'b0001` for one cycle with `rdata=0xA5…A5`, `busy` falls next cycle.
- DCache write: client 1, `we=1`, wdata `0x1234…`, addr `0x0000_2000` → `l2_write_en=1`, `l2_write_data=0x1234…`, `done=4'b0010`.
- Round-robin: `req=4'b0111` held, each L2 access completing in 1 cycle → grant order 0,1,2,0,1,2; grants spaced 3 cycles apart.
- Prefetch starvation: `req=4'b1011` continuous with `PF_MAX_WAIT=16` → client 3 is granted once `pf_wait` saturates at 16, then `pf_wait` returns to 0.
- Timeout: `TIMEOUT=8`, client 2 requests, `l2_done` never asserted → after 8 BUSY cycles, `err=4'b0100` pulses, no `done`, arbiter accepts the next request.
- Reset mid-BUSY: pull `reset` low while waiting on L2 → all outputs 0 immediately; after release, with `req=4'b0111`, client 0 is granted first.
